// File: rtl/adc_peak_pkg.sv
// Shared encodings for the ADC peak command/response engine.
package adc_peak_pkg;

  localparam logic [1:0] CMD_READ_PEAK  = 2'b00;
  localparam logic [1:0] CMD_READ_LAST  = 2'b01;
  localparam logic [1:0] CMD_CLEAR_PEAK = 2'b10;
  localparam logic [1:0] CMD_READ_ALL   = 2'b11;

  localparam logic [7:0] ACK_BYTE = 8'hAC;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SEND_HI = 2'd2,
    ST_SEND_LO = 2'd3
  } state_e;

endpackage

// File: rtl/adc_peak_responder_if.sv
// Opcode receive strobe and byte-wide valid/ready response channel.
interface adc_peak_responder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       cmd_error;

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, busy, cmd_error
  );

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, busy, cmd_error
  );
endinterface

// File: rtl/adc_peak_responder_peak_tracker.sv
// Per-channel last-sample and running-peak registers; a clear that collides
// with a new sample leaves that sample as the fresh peak.
module peak_tracker #(
  parameter int SAMPLE_W = 10
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  input  logic                clear,
  output logic [SAMPLE_W-1:0] last_sample,
  output logic [SAMPLE_W-1:0] peak_value
);

  logic [SAMPLE_W-1:0] last_r;
  logic [SAMPLE_W-1:0] peak_r;

  // Sample capture and unsigned peak tracking
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      last_r <= '0;
      peak_r <= '0;
    end else begin
      if (sample_valid) begin
        last_r <= sample;
      end
      if (clear) begin
        peak_r <= sample_valid ? sample : '0;
      end else if (sample_valid && (sample > peak_r)) begin
        peak_r <= sample;
      end
    end
  end

  assign last_sample = last_r;
  assign peak_value  = peak_r;

endmodule

// File: rtl/adc_peak_responder.sv
// Opcode decode, response snapshot buffer and byte transmit FSM for the
// per-channel ADC peak/last trackers.
module adc_peak_responder
  import adc_peak_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 10
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
  input  logic [NUM_CH-1:0]          sample_valid,
  adc_peak_responder_if.slave        bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e              state_r, state_nx_s;
  logic [1:0]          cmd_s;
  logic [5:0]          ch_field_s;
  logic [CH_W-1:0]     ch_s;
  logic                ch_bad_s;
  logic                accept_s;
  logic                more_s;
  logic [NUM_CH-1:0]   clear_s;

  logic [SAMPLE_W-1:0] peak_s [NUM_CH];
  logic [SAMPLE_W-1:0] last_s [NUM_CH];
  logic [15:0]         peak_ext_s [NUM_CH];
  logic [15:0]         last_ext_s [NUM_CH];
  logic [15:0]         sel_peak_s, sel_last_s;

  logic [15:0]         buf_r [NUM_CH];
  logic                single_r;
  logic [7:0]          single_byte_r;
  logic [CH_W-1:0]     last_idx_r, idx_r, idx_nx_s;

  logic [7:0]          tx_data_r, tx_data_nx_s;
  logic                tx_valid_r, tx_valid_nx_s;
  logic                busy_r, busy_nx_s;
  logic                cmd_error_r, cmd_error_nx_s;

  assign cmd_s      = bus.rx_data[7:6];
  assign ch_field_s = bus.rx_data[5:0];
  assign ch_s       = bus.rx_data[CH_W-1:0];
  assign ch_bad_s   = ({1'b0, ch_field_s} >= 7'(NUM_CH)) && (cmd_s != CMD_READ_ALL);
  assign accept_s   = (state_r == ST_IDLE) && bus.rx_valid;
  assign more_s     = !single_r && (idx_r != last_idx_r);

  // Per-channel clear strobe for an accepted, in-range CLEAR_PEAK
  always_comb begin
    clear_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (accept_s && !ch_bad_s && (cmd_s == CMD_CLEAR_PEAK) && (ch_s == CH_W'(k))) begin
        clear_s[k] = 1'b1;
      end else begin
        clear_s[k] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    peak_tracker #(
      .SAMPLE_W(SAMPLE_W)
    ) u_tracker (
      .clk          (clk),
      .reset_b      (reset_b),
      .sample       (sample_data[g*SAMPLE_W +: SAMPLE_W]),
      .sample_valid (sample_valid[g]),
      .clear        (clear_s[g]),
      .last_sample  (last_s[g]),
      .peak_value   (peak_s[g])
    );
  end

  // Zero-extend tracker values and mux out the addressed channel
  always_comb begin
    sel_peak_s = 16'h0000;
    sel_last_s = 16'h0000;
    for (int k = 0; k < NUM_CH; k++) begin
      peak_ext_s[k]                 = 16'h0000;
      peak_ext_s[k][SAMPLE_W-1:0]   = peak_s[k];
      last_ext_s[k]                 = 16'h0000;
      last_ext_s[k][SAMPLE_W-1:0]   = last_s[k];
      if (ch_s == CH_W'(k)) begin
        sel_peak_s = peak_ext_s[k];
        sel_last_s = last_ext_s[k];
      end else begin
        sel_peak_s = sel_peak_s;
        sel_last_s = sel_last_s;
      end
    end
  end

  // Snapshot on acceptance so later samples cannot disturb the response
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int k = 0; k < NUM_CH; k++) begin
        buf_r[k] <= 16'h0000;
      end
      single_r      <= 1'b0;
      single_byte_r <= 8'h00;
      last_idx_r    <= '0;
    end else if (accept_s) begin
      last_idx_r <= '0;
      if (ch_bad_s) begin
        single_r      <= 1'b1;
        single_byte_r <= ERR_BYTE;
      end else begin
        case (cmd_s)
          CMD_READ_PEAK: begin
            buf_r[0] <= sel_peak_s;
            single_r <= 1'b0;
          end
          CMD_READ_LAST: begin
            buf_r[0] <= sel_last_s;
            single_r <= 1'b0;
          end
          CMD_CLEAR_PEAK: begin
            single_r      <= 1'b1;
            single_byte_r <= ACK_BYTE;
          end
          CMD_READ_ALL: begin
            for (int k = 0; k < NUM_CH; k++) begin
              buf_r[k] <= peak_ext_s[k];
            end
            single_r   <= 1'b0;
            last_idx_r <= CH_W'(NUM_CH - 1);
          end
          default: begin
            single_r      <= 1'b1;
            single_byte_r <= ERR_BYTE;
          end
        endcase
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.rx_valid) state_nx_s = ST_LOAD;
        else              state_nx_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (single_r) state_nx_s = ST_SEND_LO;
        else          state_nx_s = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        if (bus.tx_ready) state_nx_s = ST_SEND_LO;
        else              state_nx_s = ST_SEND_HI;
      end
      ST_SEND_LO: begin
        if (bus.tx_ready) state_nx_s = more_s ? ST_LOAD : ST_IDLE;
        else              state_nx_s = ST_SEND_LO;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs and word index
  always_comb begin
    tx_data_nx_s = tx_data_r;
    idx_nx_s     = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) idx_nx_s = '0;
        else          idx_nx_s = idx_r;
      end
      ST_LOAD: begin
        if (single_r) tx_data_nx_s = single_byte_r;
        else          tx_data_nx_s = buf_r[idx_r][15:8];
      end
      ST_SEND_HI: begin
        if (bus.tx_ready) tx_data_nx_s = buf_r[idx_r][7:0];
        else              tx_data_nx_s = tx_data_r;
      end
      ST_SEND_LO: begin
        if (bus.tx_ready && more_s) idx_nx_s = idx_r + CH_W'(1);
        else                        idx_nx_s = idx_r;
      end
      default: begin
        tx_data_nx_s = tx_data_r;
        idx_nx_s     = idx_r;
      end
    endcase
    tx_valid_nx_s  = (state_nx_s == ST_SEND_HI) || (state_nx_s == ST_SEND_LO);
    busy_nx_s      = (state_nx_s != ST_IDLE);
    cmd_error_nx_s = bus.rx_valid && ((state_r != ST_IDLE) || ch_bad_s);
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      tx_data_r   <= 8'h00;
      tx_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      cmd_error_r <= 1'b0;
      idx_r       <= '0;
    end else begin
      tx_data_r   <= tx_data_nx_s;
      tx_valid_r  <= tx_valid_nx_s;
      busy_r      <= busy_nx_s;
      cmd_error_r <= cmd_error_nx_s;
      idx_r       <= idx_nx_s;
    end
  end

  assign bus.tx_data   = tx_data_r;
  assign bus.tx_valid  = tx_valid_r;
  assign bus.busy      = busy_r;
  assign bus.cmd_error = cmd_error_r;

endmodule

// File: tb/tb_adc_peak_responder.sv
// Directed scoreboard bench: stimulus queues expected bytes, negedge monitors
// pop and compare every transferred byte.
module tb_adc_peak_responder;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  logic [39:0] sd4 = '0;
  logic [3:0]  sv4 = '0;
  logic [95:0] sd8 = '0;
  logic [7:0]  sv8 = '0;
  logic [7:0]  q4[$];
  logic [7:0]  q8[$];
  int n_checks = 0;
  int n_fail = 0;

  adc_peak_responder_if b4();
  adc_peak_responder_if b8();

  adc_peak_responder #(.NUM_CH(4), .SAMPLE_W(10)) dut4 (
    .clk(clk), .reset_b(reset_b), .sample_data(sd4), .sample_valid(sv4), .bus(b4)
  );
  adc_peak_responder #(.NUM_CH(8), .SAMPLE_W(12)) dut8 (
    .clk(clk), .reset_b(reset_b), .sample_data(sd8), .sample_valid(sv8), .bus(b8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (reset_b && b4.tx_valid === 1'b1 && b4.tx_ready === 1'b1) begin
      if (q4.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb4_unexpected: got 0x%0h, expected no byte", b4.tx_data);
      end else begin
        check("sb4_byte", b4.tx_data, q4.pop_front());
      end
    end
    if (reset_b && b8.tx_valid === 1'b1 && b8.tx_ready === 1'b1) begin
      if (q8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb8_unexpected: got 0x%0h, expected no byte", b8.tx_data);
      end else begin
        check("sb8_byte", b8.tx_data, q8.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample4(input int k, input logic [9:0] v);
    sd4[k*10 +: 10] = v; sv4[k] = 1'b1; step(); sv4 = '0;
  endtask

  task automatic sample8(input int k, input logic [11:0] v);
    sd8[k*12 +: 12] = v; sv8[k] = 1'b1; step(); sv8 = '0;
  endtask

  task automatic cmd4(input logic [7:0] op);
    b4.rx_data = op; b4.rx_valid = 1'b1; step(); b4.rx_valid = 1'b0;
  endtask

  task automatic cmd8(input logic [7:0] op);
    b8.rx_data = op; b8.rx_valid = 1'b1; step(); b8.rx_valid = 1'b0;
  endtask

  task automatic wait4(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (q4.size() == 0 && b4.busy === 1'b0) done = 1'b1;
      else step();
    end
    check(name, done, 1);
  endtask

  task automatic wait8(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (q8.size() == 0 && b8.busy === 1'b0) done = 1'b1;
      else step();
    end
    check(name, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    b4.rx_data = 8'h00; b4.rx_valid = 1'b0; b4.tx_ready = 1'b1;
    b8.rx_data = 8'h00; b8.rx_valid = 1'b0; b8.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", b4.tx_valid, 0);
    check("rst_busy", b4.busy, 0);
    check("rst_cmd_error", b4.cmd_error, 0);
    check("rst_tx_data", b4.tx_data, 8'h00);
    reset_b = 1'b1;
    step();

    // 1: peak and last of ch2, latency and busy
    sample4(2, 10'h100); sample4(2, 10'h3FF); sample4(2, 10'h050);
    q4.push_back(8'h03); q4.push_back(8'hFF);
    cmd4(8'h02);
    check("t1_busy_after_accept", b4.busy, 1);
    check("t1_no_valid_yet", b4.tx_valid, 0);
    step();
    check("t1_valid_at_2", b4.tx_valid, 1);
    check("t1_first_byte", b4.tx_data, 8'h03);
    wait4("t1_drain_peak");
    check("t1_busy_low", b4.busy, 0);
    q4.push_back(8'h00); q4.push_back(8'h50);
    cmd4(8'h42);
    wait4("t1_drain_last");

    // 2: backpressure holds the high byte
    sample4(0, 10'h2A5);
    b4.tx_ready = 1'b0;
    q4.push_back(8'h02); q4.push_back(8'hA5);
    cmd4(8'h00);
    step();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", b4.tx_valid, 1);
      check("t2_hold_data", b4.tx_data, 8'h02);
      step();
    end
    b4.tx_ready = 1'b1;
    wait4("t2_drain");

    // 3: clear colliding with a sample keeps the sample
    sample4(1, 10'h200);
    sd4[10 +: 10] = 10'h010; sv4[1] = 1'b1;
    q4.push_back(8'hAC);
    cmd4(8'h81);
    sv4 = '0;
    wait4("t3_drain_clear");
    q4.push_back(8'h00); q4.push_back(8'h10);
    cmd4(8'h01);
    wait4("t3_drain_read");

    // 4: dump all peaks
    q4.push_back(8'hAC); cmd4(8'h80); wait4("t4_clr0");
    sample4(0, 10'h001); sample4(1, 10'h3FF);
    q4.push_back(8'hAC); cmd4(8'h82); wait4("t4_clr2");
    sample4(2, 10'h200); sample4(3, 10'h0F0);
    foreach (q4[i]) ;
    q4.push_back(8'h00); q4.push_back(8'h01); q4.push_back(8'h03); q4.push_back(8'hFF);
    q4.push_back(8'h02); q4.push_back(8'h00); q4.push_back(8'h00); q4.push_back(8'hF0);
    cmd4(8'hC0);
    wait4("t4_drain_all");

    // 5: bad channel, then a dropped command during the response
    b4.tx_ready = 1'b0;
    q4.push_back(8'hEE);
    cmd4(8'h05);
    check("t5_err_bad", b4.cmd_error, 1);
    step();
    check("t5_err_pulse_end", b4.cmd_error, 0);
    check("t5_ee_data", b4.tx_data, 8'hEE);
    cmd4(8'h41);
    check("t5_err_drop", b4.cmd_error, 1);
    check("t5_still_busy", b4.busy, 1);
    check("t5_data_held", b4.tx_data, 8'hEE);
    step();
    check("t5_err_drop_end", b4.cmd_error, 0);
    b4.tx_ready = 1'b1;
    wait4("t5_drain");
    q4.push_back(8'h03); q4.push_back(8'hFF);
    cmd4(8'h01);
    wait4("t5_peak_unchanged");

    // 6: reset in the middle of a dump
    q4.push_back(8'h00); q4.push_back(8'h01); q4.push_back(8'h03); q4.push_back(8'hFF);
    q4.push_back(8'h02); q4.push_back(8'h00); q4.push_back(8'h00); q4.push_back(8'hF0);
    cmd4(8'hC0);
    repeat (5) step();
    check("t6_bytes_sent", q4.size(), 5);
    reset_b = 1'b0;
    #1;
    check("t6_abort_valid", b4.tx_valid, 0);
    check("t6_abort_busy", b4.busy, 0);
    check("t6_abort_data", b4.tx_data, 8'h00);
    q4.delete();
    step();
    reset_b = 1'b1;
    step();
    q4.push_back(8'h00); q4.push_back(8'h00);
    cmd4(8'h01);
    wait4("t6_peak_zero");
    q4.push_back(8'h00); q4.push_back(8'h00);
    cmd4(8'h43);
    wait4("t6_last_zero");

    // 6b: wider configuration
    sample8(2, 12'h100); sample8(2, 12'h3FF); sample8(2, 12'h050);
    q8.push_back(8'h03); q8.push_back(8'hFF);
    cmd8(8'h02);
    wait8("t8_drain_peak");
    q8.push_back(8'h00); q8.push_back(8'h50);
    cmd8(8'h42);
    wait8("t8_drain_last");
    sample8(7, 12'hFED);
    q8.push_back(8'h0F); q8.push_back(8'hED);
    cmd8(8'h07);
    check("t8_no_err_ch7", b8.cmd_error, 0);
    wait8("t8_drain_ch7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
